// File: rtl/weight_load_ctrl.sv
// -----------------------------------------------------------------------------
// weight_load_ctrl
//
// Weight-loader DMA controller. Takes one tile-load command at a time from the
// head-group scheduler, range-checks it, and computes the DRAM byte address of
// the weight tile. It then fetches the tile as fixed-length read bursts and
// writes every beat into one bank of a ping-pong weight buffer.
//
// Ports
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   wl_start, wl_start_ap_vld
//                           command strobe; both high while idle = accept
//   wl_addr_sel/layer/head/tile
//                           command fields (unsigned), sampled on accept
//   wl_ready                high only while idle
//   dma_done, wl_err        one-cycle completion pulse; wl_err qualifies it
//   rd_req_*                burst request channel (len is fixed MAX_BURST-1)
//   rd_data_*               read beat channel
//   buf_we/addr/wdata       weight buffer write port, addr = {bank, beat}
//   dbg_state               current FSM state, for observation only
//
// Handshake semantics (both read channels): a transfer happens on a rising
// edge where valid and ready are both high. The request side keeps valid,
// addr and len stable until that edge. The data side raises rd_data_ready
// for the whole DATA state and counts a beat on each edge with
// rd_data_valid high.
// -----------------------------------------------------------------------------
module weight_load_ctrl #(
  parameter int                NUM_LAYERS     = 4,
  parameter int                NUM_HEADS      = 8,
  parameter int                TILES_PER_HEAD = 4,
  parameter int                NUM_MATS       = 4,
  parameter int                BEATS_PER_TILE = 64,
  parameter int                MAX_BURST      = 16,
  parameter int                DATA_W         = 128,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] WEIGHT_BASE    = '0,
  parameter int                BUF_AW         = 7
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              wl_start,
  input  logic              wl_start_ap_vld,
  input  logic [31:0]       wl_addr_sel,
  input  logic [31:0]       wl_layer,
  input  logic [31:0]       wl_head,
  input  logic [31:0]       wl_tile,
  output logic              wl_ready,
  output logic              dma_done,
  output logic              wl_err,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [7:0]        rd_req_len,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_last,
  output logic              rd_data_ready,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int NUM_BURSTS = BEATS_PER_TILE / MAX_BURST;
  localparam int BC_W       = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int BEAT_W     = BUF_AW - 1;

  localparam logic [ADDR_W-1:0] TILE_BYTES  = ADDR_W'(BEATS_PER_TILE * (DATA_W / 8));
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(MAX_BURST * (DATA_W / 8));

  logic [2:0]        state;
  logic [31:0]       cmd_sel;
  logic [31:0]       cmd_layer;
  logic [31:0]       cmd_head;
  logic [31:0]       cmd_tile;
  logic [ADDR_W-1:0] base_addr;
  logic              bank;
  logic [BC_W-1:0]   burst_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [7:0]        burst_beat;
  logic              err_flag;

  logic              cmd_accept;
  logic              range_ok;
  logic [31:0]       tile_idx;
  logic [ADDR_W-1:0] tile_base;
  logic              beat_acc;
  logic              burst_end;
  logic              last_burst;

  assign cmd_accept = (state == S_IDLE) && wl_start && wl_start_ap_vld;

  // Unsigned compares: a "negative" field is a huge value and fails here.
  assign range_ok = (cmd_sel   < 32'(NUM_MATS))   &&
                    (cmd_layer < 32'(NUM_LAYERS)) &&
                    (cmd_head  < 32'(NUM_HEADS))  &&
                    (cmd_tile  < 32'(TILES_PER_HEAD));

  // Only consumed when range_ok holds, so the 32-bit product cannot overflow.
  assign tile_idx  = ((cmd_sel * 32'(NUM_LAYERS) + cmd_layer) * 32'(NUM_HEADS)
                      + cmd_head) * 32'(TILES_PER_HEAD) + cmd_tile;
  assign tile_base = WEIGHT_BASE + ADDR_W'(tile_idx) * TILE_BYTES;

  assign beat_acc   = (state == S_DATA) && rd_data_valid;
  // Burst length is defined by the local count; rd_data_last is only checked.
  assign burst_end  = (burst_beat == 8'(MAX_BURST - 1));
  assign last_burst = (burst_cnt == BC_W'(NUM_BURSTS - 1));

  assign wl_ready      = (state == S_IDLE);
  assign dma_done      = (state == S_DONE);
  assign wl_err        = (state == S_DONE) && err_flag;
  assign rd_req_valid  = (state == S_REQ);
  assign rd_req_addr   = base_addr + ADDR_W'(burst_cnt) * BURST_BYTES;
  assign rd_req_len    = 8'(MAX_BURST - 1);
  assign rd_data_ready = (state == S_DATA);
  assign buf_we        = beat_acc;
  assign buf_addr      = {bank, beat_cnt};
  assign buf_wdata     = rd_data;
  assign dbg_state     = state;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      cmd_sel    <= '0;
      cmd_layer  <= '0;
      cmd_head   <= '0;
      cmd_tile   <= '0;
      base_addr  <= '0;
      bank       <= 1'b0;
      burst_cnt  <= '0;
      beat_cnt   <= '0;
      burst_beat <= '0;
      err_flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_accept) begin
            cmd_sel    <= wl_addr_sel;
            cmd_layer  <= wl_layer;
            cmd_head   <= wl_head;
            cmd_tile   <= wl_tile;
            burst_cnt  <= '0;
            beat_cnt   <= '0;
            burst_beat <= '0;
            err_flag   <= 1'b0;
            state      <= S_CALC;
          end
        end
        S_CALC: begin
          if (range_ok) begin
            base_addr <= tile_base;
            bank      <= cmd_tile[0];
            state     <= S_REQ;
          end else begin
            // Bad command: report it without touching the bus.
            err_flag <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_REQ: begin
          if (rd_req_ready) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_acc) begin
            if (rd_data_last != burst_end) begin
              err_flag <= 1'b1;
            end
            if (burst_end) begin
              burst_beat <= '0;
              if (last_burst) begin
                beat_cnt  <= '0;
                burst_cnt <= '0;
                state     <= S_DONE;
              end else begin
                beat_cnt  <= beat_cnt + 1'b1;
                burst_cnt <= burst_cnt + 1'b1;
                state     <= S_REQ;
              end
            end else begin
              beat_cnt   <= beat_cnt + 1'b1;
              burst_beat <= burst_beat + 8'd1;
            end
          end
        end
        S_DONE: begin
          err_flag <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_load_ctrl
//
// Directed bench for weight_load_ctrl. One initial block walks through the
// scenarios in order; a read-bus slave is modelled by tasks, and a negedge
// monitor records buffer writes, request handshakes and completion pulses.
// Expected addresses, banks, latencies and error flags are hand-computed.
// -----------------------------------------------------------------------------
module tb_weight_load_ctrl;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 32;
  localparam int BUF_AW = 7;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              wl_start;
  logic              wl_start_ap_vld;
  logic [31:0]       wl_addr_sel;
  logic [31:0]       wl_layer;
  logic [31:0]       wl_head;
  logic [31:0]       wl_tile;
  logic              wl_ready;
  logic              dma_done;
  logic              wl_err;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [7:0]        rd_req_len;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_last;
  logic              rd_data_ready;
  logic              buf_we;
  logic [BUF_AW-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic [2:0]        dbg_state;

  weight_load_ctrl dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .wl_start        (wl_start),
    .wl_start_ap_vld (wl_start_ap_vld),
    .wl_addr_sel     (wl_addr_sel),
    .wl_layer        (wl_layer),
    .wl_head         (wl_head),
    .wl_tile         (wl_tile),
    .wl_ready        (wl_ready),
    .dma_done        (dma_done),
    .wl_err          (wl_err),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_req_addr     (rd_req_addr),
    .rd_req_len      (rd_req_len),
    .rd_data_valid   (rd_data_valid),
    .rd_data         (rd_data),
    .rd_data_last    (rd_data_last),
    .rd_data_ready   (rd_data_ready),
    .buf_we          (buf_we),
    .buf_addr        (buf_addr),
    .buf_wdata       (buf_wdata),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  logic [BUF_AW+DATA_W-1:0] got_q[$];
  logic [ADDR_W-1:0]        req_q[$];
  int   req_vis_cnt = 0;
  int   done_cnt    = 0;
  int   done_cyc    = 0;
  logic done_err    = 1'b0;

  always @(negedge ap_clk) begin
    if (buf_we === 1'b1) got_q.push_back({buf_addr, buf_wdata});
    if (rd_req_valid === 1'b1) begin
      req_vis_cnt <= req_vis_cnt + 1;
      if (rd_req_ready === 1'b1) req_q.push_back(rd_req_addr);
    end
    if (dma_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      done_err <= wl_err;
    end
  end

  // ---------------- scoreboard / checks ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  int accept_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] make_data(input logic [15:0] seed, input int idx);
    return {seed, 48'h0, 32'(idx) * 32'h9E3779B1, 32'(idx)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [31:0] sel, input logic [31:0] layer,
                          input logic [31:0] head, input logic [31:0] tile);
    @(posedge ap_clk); #1;
    wl_addr_sel     = sel;
    wl_layer        = layer;
    wl_head         = head;
    wl_tile         = tile;
    wl_start        = 1'b1;
    wl_start_ap_vld = 1'b1;
    accept_cyc      = cyc;
    @(posedge ap_clk); #1;
    wl_start        = 1'b0;
    wl_start_ap_vld = 1'b0;
  endtask

  // Serves four bursts. req_wait stalls each request; toggle inserts a dead
  // cycle between beats; bad_burst/bad_beat plant an early rd_data_last;
  // poke fires a stray command while beats are flowing.
  task automatic run_slave(input logic [15:0] seed, input int req_wait, input bit toggle,
                           input int bad_burst, input int bad_beat, input bit poke);
    int t;
    int k;
    bit ph;
    logic [ADDR_W-1:0] a0;
    for (int b = 0; b < 4; b++) begin
      t = 0;
      while (rd_req_valid !== 1'b1 && t < 100) begin
        @(posedge ap_clk); #1;
        t++;
      end
      check("req_wait_bound", 64'(t < 100), 64'd1);
      if (t >= 100) return;
      a0 = rd_req_addr;
      for (int w = 0; w < req_wait; w++) begin
        @(posedge ap_clk); #1;
        check("req_hold", 64'({rd_req_valid, rd_req_len, rd_req_addr}), 64'({1'b1, 8'd15, a0}));
      end
      rd_req_ready = 1'b1;
      @(posedge ap_clk); #1;
      rd_req_ready = 1'b0;
      k = 0;
      ph = 1'b0;
      t = 0;
      while (k < 16 && t < 100) begin
        if (toggle && ph) begin
          rd_data_valid = 1'b0;
          rd_data_last  = 1'b0;
        end else begin
          rd_data_valid = 1'b1;
          rd_data       = make_data(seed, b * 16 + k);
          rd_data_last  = (k == 15) || (b == bad_burst && k == bad_beat);
        end
        if (poke && b == 1 && k == 5) begin
          wl_addr_sel     = 32'd0;
          wl_layer        = 32'd0;
          wl_head         = 32'd0;
          wl_tile         = 32'd0;
          wl_start        = 1'b1;
          wl_start_ap_vld = 1'b1;
          check("ready_low_busy", 64'(wl_ready), 64'd0);
        end
        @(posedge ap_clk); #1;
        wl_start        = 1'b0;
        wl_start_ap_vld = 1'b0;
        if (rd_data_valid) k++;
        ph = ~ph;
        t++;
      end
      check("beat_bound", 64'(k), 64'd16);
      rd_data_valid = 1'b0;
      rd_data_last  = 1'b0;
    end
  endtask

  task automatic wait_done(input int prev);
    int t;
    t = 0;
    while (done_cnt == prev && t < 20) begin
      @(negedge ap_clk); #1;
      t++;
    end
    check("done_pulse", 64'(done_cnt - prev), 64'd1);
  endtask

  task automatic do_tile(input logic [31:0] sel, input logic [31:0] layer,
                         input logic [31:0] head, input logic [31:0] tile,
                         input logic [ADDR_W-1:0] exp_base, input logic exp_bank,
                         input logic exp_err, input int exp_lat, input logic [15:0] seed,
                         input int req_wait, input bit toggle, input int bad_burst,
                         input int bad_beat, input bit poke);
    int g0;
    int r0;
    int p0;
    int mism;
    logic [BUF_AW+DATA_W-1:0] exp_q[$];
    g0 = got_q.size();
    r0 = req_q.size();
    p0 = done_cnt;
    send_cmd(sel, layer, head, tile);
    run_slave(seed, req_wait, toggle, bad_burst, bad_beat, poke);
    wait_done(p0);
    check("done_err", 64'(done_err), 64'(exp_err));
    if (exp_lat >= 0) check("latency", 64'(done_cyc - accept_cyc), 64'(exp_lat));
    check("req_count", 64'(req_q.size() - r0), 64'd4);
    for (int b = 0; b < 4; b++) begin
      if (r0 + b < req_q.size())
        check("req_addr", 64'(req_q[r0 + b]), 64'(exp_base + 32'(b) * 32'h100));
    end
    for (int k = 0; k < 64; k++) exp_q.push_back({exp_bank, 6'(k), make_data(seed, k)});
    check("wr_count", 64'(got_q.size() - g0), 64'd64);
    mism = 0;
    foreach (exp_q[k]) begin
      if (g0 + k >= got_q.size()) mism++;
      else if (got_q[g0 + k] !== exp_q[k]) mism++;
    end
    check("wr_content", 64'(mism), 64'd0);
  endtask

  task automatic do_bad_cmd(input logic [31:0] sel, input logic [31:0] layer,
                            input logic [31:0] head, input logic [31:0] tile);
    int p0;
    int v0;
    p0 = done_cnt;
    v0 = req_vis_cnt;
    send_cmd(sel, layer, head, tile);
    wait_done(p0);
    check("bad_err", 64'(done_err), 64'd1);
    check("bad_latency", 64'(done_cyc - accept_cyc), 64'd2);
    check("bad_no_req", 64'(req_vis_cnt - v0), 64'd0);
    @(posedge ap_clk); #1;
    check("bad_ready_back", 64'(wl_ready), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  int t;
  int p0;

  initial begin
    ap_rst_n        = 1'b0;
    wl_start        = 1'b0;
    wl_start_ap_vld = 1'b0;
    wl_addr_sel     = '0;
    wl_layer        = '0;
    wl_head         = '0;
    wl_tile         = '0;
    rd_req_ready    = 1'b0;
    rd_data_valid   = 1'b0;
    rd_data         = '0;
    rd_data_last    = 1'b0;

    repeat (3) @(negedge ap_clk);
    check("rst_flags", 64'({wl_ready, dma_done, wl_err, rd_req_valid, rd_data_ready, buf_we}),
          64'(6'b100000));
    check("rst_buf_addr", 64'(buf_addr), 64'd0);
    check("rst_req_addr", 64'(rd_req_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    ap_rst_n = 1'b1;

    // First tile, zero-wait slave: idx 0, bank 0.
    do_tile(0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 70, 16'h1111, 0, 1'b0, -1, -1, 1'b0);
    // idx ((1*4+2)*8+3)*4+1 = 205 -> 205*1024 = 0x33400, bank 1.
    do_tile(1, 2, 3, 1, 32'h33400, 1'b1, 1'b0, 70, 16'h2222, 0, 1'b0, -1, -1, 1'b0);

    // Out-of-range commands, including a "negative" layer.
    do_bad_cmd(0, 0, 8, 0);
    do_bad_cmd(0, 32'hFFFF_FFFF, 0, 0);
    do_bad_cmd(4, 0, 0, 0);

    // Largest legal tile, stalled requests and gappy data:
    // idx ((3*4+3)*8+7)*4+3 = 511 -> 0x7FC00, bank 1.
    do_tile(3, 3, 7, 3, 32'h7FC00, 1'b1, 1'b0, -1, 16'h3333, 5, 1'b1, -1, -1, 1'b0);

    // Early last on beat 10 of burst 2: idx ((2*4+1)*8+0)*4+2 = 290 -> 0x48800.
    do_tile(2, 1, 0, 2, 32'h48800, 1'b0, 1'b1, 70, 16'h4444, 0, 1'b0, 2, 10, 1'b0);

    // Stray command mid-DATA: idx ((0*4+3)*8+2)*4+0 = 104 -> 0x1A000.
    do_tile(0, 3, 2, 0, 32'h1A000, 1'b0, 1'b0, 70, 16'h5555, 0, 1'b0, -1, -1, 1'b1);
    repeat (3) @(posedge ap_clk);
    #1;
    check("stray_ignored", 64'({dbg_state, wl_ready}), 64'({3'd0, 1'b1}));

    // Reset in the middle of a data burst.
    p0 = done_cnt;
    send_cmd(0, 1, 1, 0);
    t = 0;
    while (rd_req_valid !== 1'b1 && t < 20) begin
      @(posedge ap_clk); #1;
      t++;
    end
    check("mid_req_seen", 64'(rd_req_valid), 64'd1);
    rd_req_ready = 1'b1;
    @(posedge ap_clk); #1;
    rd_req_ready  = 1'b0;
    rd_data_valid = 1'b1;
    rd_data       = make_data(16'hDEAD, 0);
    rd_data_last  = 1'b0;
    repeat (3) begin
      @(posedge ap_clk); #1;
    end
    check("mid_streaming", 64'({rd_data_ready, buf_we}), 64'(2'b11));
    ap_rst_n = 1'b0;
    #1;
    check("rst_async_drop", 64'({rd_data_ready, buf_we, wl_ready, rd_req_valid}), 64'(4'b0010));
    rd_data_valid = 1'b0;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    check("rst_no_done", 64'(done_cnt - p0), 64'd0);

    // Fresh command after the abort: idx (0*8+1)*4+1 = 5 -> 0x1400, bank 1.
    do_tile(0, 0, 1, 1, 32'h1400, 1'b1, 1'b0, 70, 16'h6666, 0, 1'b0, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/weight_load_ctrl.md
Name: weight_load_ctrl

Overview:
Weight-loader (WL) DMA controller sitting directly downstream of the head-group scheduler's wl_* command outputs. It accepts one tile-load command at a time and computes the DRAM byte address of the requested weight tile. It fetches the tile as fixed-length read bursts, writes the beats into a ping-pong weight buffer, and reports status back through wl_ready and dma_done.

Parameters:
NUM_LAYERS, 4, number of transformer layers
NUM_HEADS, 8, heads per layer
TILES_PER_HEAD, 4, weight tiles per head per matrix
NUM_MATS, 4, matrices selectable by wl_addr_sel (Q, K, V, O)
BEATS_PER_TILE, 64, data beats per tile; must be a multiple of MAX_BURST
MAX_BURST, 16, beats per read burst
DATA_W, 128, read data and buffer width
ADDR_W, 32, byte address width
WEIGHT_BASE, 32'h0, DRAM byte base of the weight region
BUF_AW, 7, buffer address width, equal to log2(BEATS_PER_TILE)+1

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
wl_start  in  1  load request from scheduler
wl_start_ap_vld  in  1  qualifies wl_start
wl_addr_sel  in  32  matrix select, legal range 0..NUM_MATS-1
wl_layer  in  32  layer index
wl_head  in  32  head index
wl_tile  in  32  tile index
wl_ready  out  1  controller idle, can accept a command
dma_done  out  1  one-cycle completion pulse
wl_err  out  1  qualifies dma_done; command failed
rd_req_valid  out  1  burst request valid
rd_req_ready  in  1  burst request accepted
rd_req_addr  out  ADDR_W  burst start byte address
rd_req_len  out  8  beats minus 1, constant MAX_BURST-1
rd_data_valid  in  1  read beat valid
rd_data  in  DATA_W  read beat data
rd_data_last  in  1  last beat of burst
rd_data_ready  out  1  beat accept
buf_we  out  1  buffer write enable
buf_addr  out  BUF_AW  buffer address {bank, beat}
buf_wdata  out  DATA_W  buffer write data

Behaviour:
- Reset (asynchronous, ap_rst_n low): state = IDLE; all counters cleared.
  - Output values in reset: wl_ready=1; dma_done=0; wl_err=0; rd_req_valid=0; rd_data_ready=0; buf_we=0; buf_addr=0; rd_req_addr=0.
  - Reset asserted mid-transfer aborts the command with no dma_done. The read-bus slave shares this reset, so no beats are left outstanding.
- Command accept: wl_start && wl_start_ap_vld && state==IDLE.
  - Command fields are registered on the accept cycle.
  - A command arriving when not in IDLE is ignored. wl_ready is low in every state except IDLE.
- State machine: IDLE -> CALC -> REQ <-> DATA -> DONE -> IDLE.
- CALC (1 cycle):
  - Range check: addr_sel<NUM_MATS, layer<NUM_LAYERS, head<NUM_HEADS, tile<TILES_PER_HEAD. Operands are unsigned; negative values read as huge and therefore fail.
  - On failure: go to DONE with the error set; no bus traffic.
  - tile_idx = ((addr_sel*NUM_LAYERS + layer)*NUM_HEADS + head)*TILES_PER_HEAD + tile.
  - base = WEIGHT_BASE + tile_idx*BEATS_PER_TILE*(DATA_W/8), truncated to ADDR_W.
  - bank = tile[0].
- REQ:
  - rd_req_valid=1 with rd_req_addr = base + burst_cnt*MAX_BURST*(DATA_W/8).
  - Addr and len are held stable until rd_req_ready. On the handshake cycle go to DATA.
- DATA:
  - rd_data_ready=1. Only one burst is outstanding at a time.
  - Each accepted beat: buf_we=1 in the same cycle, buf_addr={bank, beat_cnt}, buf_wdata=rd_data; beat_cnt increments.
  - Burst end is defined by local count MAX_BURST, not by last. If rd_data_last disagrees with the count at any beat, set the error flag and continue.
  - After the final beat of a burst: if burst_cnt == BEATS_PER_TILE/MAX_BURST-1, go to DONE; else increment burst_cnt and return to REQ.
- DONE (1 cycle): dma_done=1 and wl_err=error flag; then return to IDLE and clear the flag.
  - A new command is accepted on the cycle after DONE at the earliest.
- Latency for the default 4 bursts: 1 (CALC) + per-burst request handshake + 16 beats each + 1 (DONE).
  - Minimum accept-to-dma_done latency with zero-wait slave: 1 + 4*(1+16) + 1 = 70 cycles.
- beat_cnt wraps from BEATS_PER_TILE-1 to 0 only at tile end. The bank bit isolates consecutive tiles so compute can read one bank while the other fills.

Test Plan:
1. Reset release, then command sel=0 layer=0 head=0 tile=0, zero-wait slave -> rd_req_addr = 0x000, 0x100, 0x200, 0x300; 64 buf_we pulses at buf_addr 0..63; dma_done=1 with wl_err=0 exactly 70 cycles after accept.
2. sel=1 layer=2 head=3 tile=1 -> tile_idx = ((1*4+2)*8+3)*4+1 = 205; first rd_req_addr = 205*1024 = 0x33400; buf_addr 64..127 (bank 1).
3. wl_head=8 -> no rd_req_valid; dma_done=1 and wl_err=1 two cycles after accept; wl_ready returns to 1.
4. rd_req_ready held low 5 cycles and rd_data_valid toggled 1/0 -> addr/len held stable while waiting; exactly 64 writes; data order preserved.
5. rd_data_last asserted on beat 10 of burst 2 -> transfer still completes 64 beats; dma_done with wl_err=1.
6. wl_start pulse while in DATA is ignored. ap_rst_n asserted mid-DATA -> rd_data_ready/buf_we drop asynchronously; wl_ready=1; no dma_done. A fresh command then completes normally.
